// File: rtl/dense_mac_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dense_mac_engine_pkg
// Description : Shared constants and FSM state type for the dense-layer
//               multiply-accumulate engine.
// Revision    : 1.0 - initial release
// ============================================================================
package dense_mac_engine_pkg;

  // Weight-memory addressing; ADDR_IDLE is out of range and reads as zeros.
  localparam int              ADDR_WIDTH = 8;
  localparam logic [7:0]      ADDR_IDLE  = 8'hFF;

  // IEEE-754 single-precision constants.
  localparam logic [31:0]     FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0]     FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0]     FP_QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dense_mac_engine_fp_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_add
// Description : Combinational single-precision y = a*b + c. Multiply and add
//               are rounded separately (nearest-even); subnormals flush to
//               signed zero, overflow saturates to inf, NaNs are canonical.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_add
  import dense_mac_engine_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic [31:0] y_o
);

  // Round a normalised 24-bit mantissa and range-check the exponent.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e,
                                          input logic [23:0] m, input logic inc);
    logic [24:0]        mr;
    logic signed [10:0] ee;
    mr = {1'b0, m} + {24'd0, inc};
    // A rounding carry turns 1.111..1 into 10.000..0: bump the exponent.
    ee = e + $signed({10'd0, mr[24]});
    if (ee >= 11'sd255)    fp_pack = {s, 8'hFF, 23'd0};
    else if (ee <= 11'sd0) fp_pack = {s, 31'd0};
    else                   fp_pack = {s, ee[7:0], mr[24] ? mr[23:1] : mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
    logic [47:0]        p;
    logic [23:0]        m;
    logic signed [10:0] e;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'd0, a[30:23]}) + $signed({3'd0, b[30:23]}) - 11'sd127;
    // Product of two [1,2) mantissas lies in [1,4); normalise by at most one.
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 11'sd1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) fp_mul = FP_QNAN;
    else if (a_inf || b_inf)                                      fp_mul = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                    fp_mul = {s, 31'd0};
    else                                                          fp_mul = fp_pack(s, e, m, g & (st | m[0]));
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] c);
    logic               a_zero, c_zero, a_inf, c_inf, a_nan, c_nan, swap, found;
    logic [31:0]        big, sml;
    logic [7:0]         d;
    logic [49:0]        sh;
    logic [26:0]        mb, ms, m27;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [10:0] e;
    a_zero = (a[30:23] == 8'd0);
    c_zero = (c[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    c_inf  = (c[30:23] == 8'hFF) && (c[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    c_nan  = (c[30:23] == 8'hFF) && (c[22:0] != 23'd0);
    swap   = (c[30:0] > a[30:0]);
    big    = swap ? c : a;
    sml    = swap ? a : c;
    d      = big[30:23] - sml[30:23];
    // Mantissas carry three extra bits (guard, round, sticky).
    mb     = {1'b1, big[22:0], 3'd0};
    sh     = {1'b1, sml[22:0], 26'd0} >> d;
    ms     = (d > 8'd49) ? 27'd1 : {sh[49:24], |sh[23:0]};
    e      = $signed({3'd0, big[30:23]});
    lz     = '0;
    found  = 1'b0;
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (sum[27]) begin
        m27 = {sum[27:2], |sum[1:0]};
        e   = e + 11'sd1;
      end else begin
        m27 = sum[26:0];
      end
    end else begin
      sum = {1'b0, mb} - {1'b0, ms};
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else        lz    = lz + 5'd1;
        end
      end
      m27 = sum[26:0] << lz;
      e   = e - $signed({6'd0, lz});
    end
    if (a_nan || c_nan || (a_inf && c_inf && (a[31] != c[31]))) fp_add = FP_QNAN;
    else if (a_inf)            fp_add = a;
    else if (c_inf)            fp_add = c;
    else if (a_zero && c_zero) fp_add = {a[31] & c[31], 31'd0};
    else if (a_zero)           fp_add = c;
    else if (c_zero)           fp_add = a;
    else if (m27 == 27'd0)     fp_add = FP_ZERO;
    else fp_add = fp_pack(big[31], e, m27[26:3], m27[2] & (m27[3] | (|m27[1:0])));
  endfunction

  // Multiply, round, then add the running sum and round again.
  always_comb y_o = fp_add(fp_mul(a_i, b_i), c_i);

endmodule
`default_nettype wire

// File: rtl/dense_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : dense_mac_engine
// Description : Walks the weight memory one row per cycle and accumulates
//               x[k]*w_k[i] into OUTPUT_NODES single-precision accumulators,
//               then applies optional ReLU and strobes out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_mac_engine
  import dense_mac_engine_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int INPUT_NODES  = 100,
  parameter int OUTPUT_NODES = 32,
  parameter int RELU         = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0]  in_data,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] bias,
  output logic [ADDR_WIDTH-1:0]              address,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] out_data,
  output logic                               out_valid,
  output logic                               busy
);

  localparam int         XW       = DATA_WIDTH * INPUT_NODES;
  localparam int         VW       = DATA_WIDTH * OUTPUT_NODES;
  localparam logic [8:0] LAST_ROW = 9'(INPUT_NODES);

  state_e                state_q, state_d;
  logic [8:0]            cyc_q, cyc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XW-1:0]         x_q, x_d;
  logic [VW-1:0]         acc_q, acc_d, mac_res, out_q, out_d;
  logic                  valid_q, valid_d, busy_q, busy_d;

  // One MAC per output column; the activation for the current row sits at
  // the top of x_q, which shifts up one node per consumed row.
  for (genvar i = 0; i < OUTPUT_NODES; i++) begin : g_mac
    fp_mul_add u_fp_mul_add (
      .a_i (x_q[XW-1 -: DATA_WIDTH]),
      .b_i (weights[i*DATA_WIDTH +: DATA_WIDTH]),
      .c_i (acc_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .y_o (mac_res[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Next-state logic. cyc_q counts RUN edges; row k is consumed when
  // cyc_q == k+1, one cycle after its address was issued (memory latency).
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    x_d     = x_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        addr_d = ADDR_IDLE;
        if (start) begin
          state_d = ST_RUN;
          x_d     = in_data;
          acc_d   = bias;
          addr_d  = '0;
          cyc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        cyc_d  = cyc_q + 9'd1;
        addr_d = (cyc_q + 9'd1 < LAST_ROW) ? cyc_q[7:0] + 8'd1 : ADDR_IDLE;
        if (cyc_q != 9'd0) begin
          acc_d = mac_res;
          x_d   = x_q << DATA_WIDTH;
        end
        if (cyc_q == LAST_ROW) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        for (int i = 0; i < OUTPUT_NODES; i++) begin
          out_d[i*DATA_WIDTH +: DATA_WIDTH] =
            ((RELU != 0) && acc_q[i*DATA_WIDTH + DATA_WIDTH - 1]) ?
              FP_ZERO : acc_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous abort to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      addr_q  <= ADDR_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign address   = addr_q;
  assign out_data  = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/dense_mac_engine.md
Name: dense_mac_engine

Overview:
Downstream consumer of the dense-layer weight memory. On a start pulse it latches one input activation vector and a bias vector. It then walks the weight memory address over all input nodes, consuming one weight row per cycle, and accumulates into OUTPUT_NODES parallel single-precision IEEE-754 accumulators. It finishes with optional ReLU and a one-cycle out_valid strobe to the next layer.

Parameters:
DATA_WIDTH, 32, word width; only 32 (IEEE-754 single precision) is supported.
INPUT_NODES, 100, rows walked per inference; legal range is 1..255.
OUTPUT_NODES, 32, parallel accumulators, equal to the weight-row length.
RELU, 1, when 1 apply ReLU to outputs; when 0 pass raw sums through.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
in_data  input  DATA_WIDTH*INPUT_NODES  activation vector; node j at bits [(INPUT_NODES-1-j)*DATA_WIDTH +: DATA_WIDTH].
bias  input  DATA_WIDTH*OUTPUT_NODES  bias vector; node i packed MSB-first, same scheme as in_data.
address  output  8  weight memory row address; registered.
weights  input  DATA_WIDTH*OUTPUT_NODES  weight row from memory; node i at [(OUTPUT_NODES-1-i)*DATA_WIDTH +: DATA_WIDTH].
out_data  output  DATA_WIDTH*OUTPUT_NODES  result vector, packed MSB-first; held until the next completion.
out_valid  output  1  one-cycle completion strobe.
busy  output  1  high while an inference is in flight.

Behaviour:
- Clocking and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values: address=8'hFF, out_data=0, out_valid=0, busy=0, accumulators=0, state=IDLE.
- Memory contract: the memory samples address on a rising edge and presents that row after the same edge. Read latency is 1 cycle. Out-of-range address 8'hFF returns an all-zero row.
- FSM states:
  - IDLE: address=8'hFF, busy=0.
  - On start=1 at edge E0: latch in_data and bias; acc[i]<=bias[i]; address<=0; row counter=0; go to RUN.
- RUN, issue side: after edge E(k), address=k for k=0..INPUT_NODES-1. After the last address is issued, address<=8'hFF at edge E(INPUT_NODES).
- RUN, consume side: at edge E(k+2), acc[i] <= acc[i] + x[k]*w_k[i], for k=0..INPUT_NODES-1. The last accumulate happens at E(INPUT_NODES+1); go to FINISH.
- FINISH: at E(INPUT_NODES+2), out_data[i] <= (RELU && sign(acc[i])) ? 32'h0 : acc[i]; out_valid<=1; busy<=0; state<=IDLE.
- Latency: out_valid is high during the cycle after E(INPUT_NODES+2), i.e. INPUT_NODES+2 cycles after start is sampled.
- busy is 1 from after E0 until out_valid rises.
- start while busy: ignored; no queuing.
- start sampled during the out_valid cycle: accepted, because the FSM is already in IDLE. This gives back-to-back inferences with no bubble beyond latency.
- Arithmetic: x*w+acc is computed as a multiply then an add, each rounded to nearest-even.
  - Subnormal inputs and results flush to signed zero.
  - Overflow produces ±inf.
  - Any NaN, or inf-inf, produces canonical 32'h7FC00000.
  - ReLU maps -0.0 to +0.0; NaN has sign 0 and passes through unchanged.
- Reset mid-inference: immediate abort to reset values. out_valid is never asserted for the aborted run.
- in_data and bias may change after E0 without effect.

Decomposition:
- Shared include dense_defs.vh holds:
  - ADDR_WIDTH=8, ADDR_IDLE=8'hFF.
  - State encodings IDLE/RUN/FINISH.
  - FP constants FP_ZERO=32'h0, FP_ONE=32'h3F800000, FP_QNAN=32'h7FC00000.
- One sub-module, fp_mul_add: combinational single-precision a*b+c with the rounding and special-case rules above. Instantiate it OUTPUT_NODES times via a generate loop.
- FSM, counters and accumulator registers live in the top module.

Test Plan:
All cases use INPUT_NODES=4, OUTPUT_NODES=2, and a memory model with 1-cycle latency.
1. Basic sum: all weights 1.0, in_data={1.0,2.0,3.0,4.0}, bias 0 -> out_data={32'h41200000, 32'h41200000} (10.0).
   - out_valid rises exactly 6 cycles after start is sampled and lasts 1 cycle.
   - address sequence is FF,0,1,2,3,FF.
2. Bias and ReLU: case 1 with bias={-20.0,+5.0}.
   - RELU=1 -> {32'h00000000, 32'h41700000}.
   - RELU=0 -> {32'hC1200000, 32'h41700000}.
3. Back-to-back: start held high continuously.
   - Second run's address 0 appears on the cycle after the first out_valid.
   - Two out_valid pulses, 7 cycles apart.
4. Start while busy: pulse start at cycle 2 of a run -> ignored; a single out_valid; result is unchanged versus case 1.
5. Reset mid-run: assert rst_n=0 at cycle 3 -> address=FF and busy=0 immediately.
   - No out_valid follows.
   - A fresh start then gives the case-1 result.
6. Special values: weight row 0 = {inf, NaN}, in_data[0]=0.0 -> out_data={32'h7FC00000, 32'h7FC00000}. Both columns are NaN: 0*inf and NaN propagation respectively.
